// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite command master and anything that talks
// to it: the AXI response codes and the master's state encoding.
// No ports; import with "import axi_lite_pkg::*;".
// ---------------------------------------------------------------------------
package axi_lite_pkg;

  // AXI RRESP / BRESP encodings
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Command master FSM encoding, kept as plain constants so older tools and
  // hand-written decoders elsewhere in the tree can use the same values.
  typedef logic [2:0] state_t;

  localparam state_t IDLE       = 3'd0;
  localparam state_t WRITE      = 3'd1;
  localparam state_t WRITE_RESP = 3'd2;
  localparam state_t READ_ADDR  = 3'd3;
  localparam state_t READ_DATA  = 3'd4;
  localparam state_t RESPOND    = 3'd5;

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_master_if
// AXI4-Lite bus bundle used between the command master and a slave.
// Parameters:
//   axi_width  - data width in bits (32 or 64)
//   addr_width - byte address width in bits
// Channels:
//   AW: awaddr, awprot, awvalid / awready
//   W : wdata, wstrb, wvalid / wready
//   B : bresp, bvalid / bready
//   AR: araddr, arprot, arvalid / arready
//   R : rdata, rresp, rvalid / rready
// Modports: master (drives AW/W/AR and the B/R readies), slave (the mirror).
// ---------------------------------------------------------------------------
interface axi_lite_cmd_master_if #(
  parameter int axi_width  = 32,
  parameter int addr_width = 12
);

  logic [addr_width-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [axi_width-1:0]    wdata;
  logic [axi_width/8-1:0]  wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [addr_width-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [axi_width-1:0]    rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_master
// Turns single read/write commands into AXI4-Lite transactions, one at a time,
// and hands the slave's answer back on a response handshake.
// Parameters:
//   axi_width  - data width in bits (32 or 64)
//   addr_width - byte address width in bits
// Ports:
//   clk, rst_n            - rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready   - command handshake
//   cmd_write             - 1 = write, 0 = read
//   cmd_addr/wdata/wstrb  - target byte address, write data, byte strobes
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata             - read data (0 for writes)
//   rsp_resp              - RRESP/BRESP of the transaction, unmodified
//   rsp_write             - echo of the command's write flag
//   busy                  - high from command acceptance to response acceptance
//   m_axi                 - AXI4-Lite master port (axi_lite_cmd_master_if.master)
// ---------------------------------------------------------------------------
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int axi_width  = 32,
  parameter int addr_width = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [addr_width-1:0]  cmd_addr,
  input  logic [axi_width-1:0]   cmd_wdata,
  input  logic [axi_width/8-1:0] cmd_wstrb,

  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [axi_width-1:0]   rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic                   rsp_write,
  output logic                   busy,

  axi_lite_cmd_master_if.master  m_axi
);

  state_t                 state;
  logic                   ready_en;
  logic                   awvalid_q;
  logic                   wvalid_q;
  logic                   arvalid_q;
  logic [addr_width-1:0]  addr_q;
  logic [axi_width-1:0]   wdata_q;
  logic [axi_width/8-1:0] wstrb_q;
  logic                   write_q;
  logic [axi_width-1:0]   rdata_q;
  logic [1:0]             resp_q;
  logic                   aw_done;
  logic                   w_done;

  // ready_en holds cmd_ready low through reset and lets it rise on the first
  // clock after rst_n deasserts, while state is already IDLE.
  assign cmd_ready = ready_en && (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESPOND);
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign rsp_write = write_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = (state == WRITE_RESP);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = (state == READ_DATA);

  // Inside WRITE a channel's valid is only low once its handshake has
  // happened, so "done by this edge" is either already-dropped or handshaking
  // right now. This covers AW and W finishing together or in either order.
  assign aw_done = !awvalid_q || m_axi.awready;
  assign w_done  = !wvalid_q  || m_axi.wready;

  // Main sequencer. Valids are registered so they never follow the slave's
  // ready combinationally; slave responses are only looked at in the state
  // that expects them, anything else is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready_en  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= AXI_RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            write_q <= cmd_write;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WRITE;
            end else begin
              arvalid_q <= 1'b1;
              state     <= READ_ADDR;
            end
          end
        end

        WRITE: begin
          if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done)          state     <= WRITE_RESP;
        end

        WRITE_RESP: begin
          if (m_axi.bvalid) begin
            resp_q  <= m_axi.bresp;
            rdata_q <= '0;
            state   <= RESPOND;
          end
        end

        READ_ADDR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            state     <= READ_DATA;
          end
        end

        READ_DATA: begin
          if (m_axi.rvalid) begin
            rdata_q <= m_axi.rdata;
            resp_q  <= m_axi.rresp;
            state   <= RESPOND;
          end
        end

        RESPOND: begin
          if (rsp_ready) state <= IDLE;
        end

        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          arvalid_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_cmd_master
// Directed bench for axi_lite_cmd_master with a 16-word register slave whose
// ready/valid stalls are set per step.
// ---------------------------------------------------------------------------
module tb_axi_lite_cmd_master;
  import axi_lite_pkg::*;

  localparam int AXW = 32;
  localparam int ADW = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_write = 1'b0;
  logic [ADW-1:0]  cmd_addr = '0;
  logic [AXW-1:0]  cmd_wdata = '0;
  logic [3:0]      cmd_wstrb = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [AXW-1:0]  rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            rsp_write;
  logic            busy;

  always #5 clk = ~clk;

  axi_lite_cmd_master_if #(.axi_width(AXW), .addr_width(ADW)) axi ();

  axi_lite_cmd_master #(.axi_width(AXW), .addr_width(ADW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .rsp_write (rsp_write),
    .busy      (busy),
    .m_axi     (axi)
  );

  int checks = 0;
  int fails = 0;

  // slave configuration, set by the stimulus between transactions
  int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] bresp_cfg = AXI_RESP_OKAY;
  logic [1:0] rresp_cfg = AXI_RESP_OKAY;

  // slave state
  logic [31:0] mem [16];
  logic        have_aw, have_w, have_ar;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0, ar_hs = 1'b0, r_hs = 1'b0;
  logic [ADW-1:0] aw_addr_s = '0, ar_addr_s = '0;
  logic [31:0] w_data_s = '0;
  logic [3:0]  w_strb_s = '0;
  int          write_count = 0;
  logic        early_bready = 1'b0;
  int          proto_viol = 0;

  // previous-cycle bus values for the stability monitor
  logic           p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
  logic           p_arv = 1'b0, p_arr = 1'b0, p_rspv = 1'b0, p_rspr = 1'b0;
  logic [ADW-1:0] p_awaddr = '0, p_araddr = '0;
  logic [31:0]    p_wdata = '0, p_rdata = '0;
  logic [3:0]     p_wstrb = '0;
  logic [1:0]     p_resp = '0;
  logic           p_rspw = 1'b0;

  // Handshake recorder and protocol monitor: valids must hold with stable
  // payload until ready, and the response must hold until rsp_ready.
  always @(posedge clk) begin : monitor
    int v;
    v = 0;
    aw_hs <= axi.awvalid && axi.awready;
    w_hs  <= axi.wvalid  && axi.wready;
    b_hs  <= axi.bvalid  && axi.bready;
    ar_hs <= axi.arvalid && axi.arready;
    r_hs  <= axi.rvalid  && axi.rready;
    if (axi.awvalid && axi.awready) aw_addr_s <= axi.awaddr;
    if (axi.wvalid && axi.wready) begin
      w_data_s <= axi.wdata;
      w_strb_s <= axi.wstrb;
    end
    if (axi.arvalid && axi.arready) ar_addr_s <= axi.araddr;
    if (rst_n) begin
      if (p_awv && !p_awr && (!axi.awvalid || axi.awaddr !== p_awaddr)) v++;
      if (p_wv && !p_wr && (!axi.wvalid || axi.wdata !== p_wdata || axi.wstrb !== p_wstrb)) v++;
      if (p_arv && !p_arr && (!axi.arvalid || axi.araddr !== p_araddr)) v++;
      if (p_rspv && !p_rspr && (!rsp_valid || rsp_rdata !== p_rdata ||
                                rsp_resp !== p_resp || rsp_write !== p_rspw)) v++;
      if (axi.bready && axi.rready) v++;
      if (axi.awprot !== 3'b000 || axi.arprot !== 3'b000) v++;
    end
    proto_viol <= proto_viol + v;
    p_awv <= axi.awvalid; p_awr <= axi.awready; p_awaddr <= axi.awaddr;
    p_wv <= axi.wvalid; p_wr <= axi.wready; p_wdata <= axi.wdata; p_wstrb <= axi.wstrb;
    p_arv <= axi.arvalid; p_arr <= axi.arready; p_araddr <= axi.araddr;
    p_rspv <= rsp_valid; p_rspr <= rsp_ready; p_rdata <= rsp_rdata;
    p_resp <= rsp_resp; p_rspw <= rsp_write;
  end

  // Register slave, driven on the falling edge from handshakes recorded at
  // the preceding rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
      have_aw = 1'b0; have_w = 1'b0; have_ar = 1'b0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
    end else begin
      if (b_hs) begin
        axi.bvalid = 1'b0; have_aw = 1'b0; have_w = 1'b0; b_cnt = 0;
      end
      if (aw_hs) begin
        axi.awready = 1'b0; have_aw = 1'b1; aw_cnt = 0;
      end else if (axi.awvalid && !have_aw) begin
        if (aw_cnt >= aw_delay) axi.awready = 1'b1;
        else aw_cnt++;
      end
      if (w_hs) begin
        axi.wready = 1'b0; have_w = 1'b1; w_cnt = 0;
      end else if (axi.wvalid && !have_w) begin
        if (w_cnt >= w_delay) axi.wready = 1'b1;
        else w_cnt++;
      end
      if (have_aw && have_w && !axi.bvalid) begin
        if (b_cnt >= b_delay) begin
          for (int i = 0; i < 4; i++)
            if (w_strb_s[i]) mem[aw_addr_s[5:2]][8*i +: 8] = w_data_s[8*i +: 8];
          write_count++;
          axi.bvalid = 1'b1;
          axi.bresp  = bresp_cfg;
        end else b_cnt++;
      end
      if (axi.bready && !(have_aw && have_w)) early_bready = 1'b1;

      if (r_hs) begin
        axi.rvalid = 1'b0; have_ar = 1'b0; r_cnt = 0;
      end
      if (ar_hs) begin
        axi.arready = 1'b0; have_ar = 1'b1; ar_cnt = 0;
      end else if (axi.arvalid && !have_ar) begin
        if (ar_cnt >= ar_delay) axi.arready = 1'b1;
        else ar_cnt++;
      end
      if (have_ar && !axi.rvalid && !r_hs) begin
        if (r_cnt >= r_delay) begin
          axi.rvalid = 1'b1;
          axi.rdata  = mem[ar_addr_s[5:2]];
          axi.rresp  = rresp_cfg;
        end else r_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command at a falling edge; returns at the falling edge right
  // after the accepting rising edge.
  task automatic issue(input logic wr, input logic [ADW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept_timeout", {63'd0, cmd_ready}, 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("cmd_ready_after_rsp", {63'd0, cmd_ready}, 64'd1);
    check("busy_after_rsp", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int cyc, wc, n, exp_writes;
    logic [31:0] ref_mem [16];
    logic        wr;
    logic [3:0]  idx, s;
    logic [31:0] d, exp_data;
    logic [1:0]  exp_resp;

    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_valids", {61'd0, axi.awvalid, axi.wvalid, axi.arvalid}, 64'd0);
    check("rst_readies", {62'd0, axi.bready, axi.rready}, 64'd0);
    check("rst_awaddr", {52'd0, axi.awaddr}, 64'd0);
    check("rst_wdata", {32'd0, axi.wdata}, 64'd0);
    check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("rst_rsp_resp", {62'd0, rsp_resp}, 64'd0);
    #2 rst_n = 1'b1;
    #1 check("cmd_ready_just_released", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk);
    check("cmd_ready_first_cycle", {63'd0, cmd_ready}, 64'd1);

    // ---- zero-wait write: accept cycle + WRITE + WRITE_RESP + RESPOND ----
    wc = write_count;
    issue(1'b1, 12'h004, 32'h0000_0001, 4'hF);
    check("wr_awaddr", {52'd0, axi.awaddr}, 64'h004);
    check("wr_wdata", {32'd0, axi.wdata}, 64'h1);
    check("wr_wstrb", {60'd0, axi.wstrb}, 64'hF);
    check("wr_aw_w_valid", {62'd0, axi.awvalid, axi.wvalid}, 64'h3);
    check("wr_busy", {63'd0, busy}, 64'd1);
    check("wr_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
    wait_rsp(cyc);
    check("wr_latency", 64'(cyc + 2), 64'd4);
    check("wr_rsp_resp", {62'd0, rsp_resp}, 64'd0);
    check("wr_rsp_write", {63'd0, rsp_write}, 64'd1);
    check("wr_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    take_rsp();
    check("wr_count", 64'(write_count - wc), 64'd1);
    ref_mem[1] = 32'h0000_0001;

    // ---- zero-wait read latency ----
    issue(1'b0, 12'h004, 32'h0, 4'h0);
    wait_rsp(cyc);
    check("rd_latency", 64'(cyc + 2), 64'd4);
    check("rd_rdata_004", {32'd0, rsp_rdata}, 64'h1);
    check("rd_rsp_write", {63'd0, rsp_write}, 64'd0);
    take_rsp();

    // ---- read with 3 arready and 2 rvalid wait states ----
    issue(1'b1, 12'h008, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(cyc);
    take_rsp();
    ref_mem[2] = 32'hDEAD_BEEF;
    ar_delay = 3; r_delay = 2;
    issue(1'b0, 12'h008, 32'h0, 4'h0);
    check("ar_araddr", {52'd0, axi.araddr}, 64'h008);
    check("ar_rready_low", {63'd0, axi.rready}, 64'd0);
    repeat (3) @(negedge clk);
    check("ar_held", {63'd0, axi.arvalid}, 64'd1);
    @(negedge clk);
    check("ar_dropped", {63'd0, axi.arvalid}, 64'd0);
    check("rd_rready_high", {63'd0, axi.rready}, 64'd1);
    wait_rsp(cyc);
    check("rd_rdata_beef", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
    check("rd_resp_okay", {62'd0, rsp_resp}, 64'd0);
    take_rsp();
    ar_delay = 0; r_delay = 0;

    // ---- W handshake 5 cycles before AW ----
    aw_delay = 5; w_delay = 0; wc = write_count;
    issue(1'b1, 12'h00C, 32'h1234_5678, 4'h3);
    @(negedge clk);
    check("wfirst_wvalid_drop", {62'd0, axi.wvalid, axi.awvalid}, 64'h1);
    check("wfirst_bready_low", {63'd0, axi.bready}, 64'd0);
    repeat (4) @(negedge clk);
    check("wfirst_aw_waiting", {62'd0, axi.awvalid, axi.bready}, 64'h2);
    @(negedge clk);
    check("wfirst_aw_drop", {62'd0, axi.awvalid, axi.bready}, 64'h1);
    wait_rsp(cyc);
    take_rsp();
    check("wfirst_one_write", 64'(write_count - wc), 64'd1);
    ref_mem[3] = 32'h0000_5678;

    // ---- AW handshake 5 cycles before W ----
    aw_delay = 0; w_delay = 5; wc = write_count;
    issue(1'b1, 12'h00C, 32'hAABB_CCDD, 4'hC);
    @(negedge clk);
    check("awfirst_awvalid_drop", {62'd0, axi.awvalid, axi.wvalid}, 64'h1);
    check("awfirst_bready_low", {63'd0, axi.bready}, 64'd0);
    repeat (5) @(negedge clk);
    check("awfirst_w_drop", {62'd0, axi.wvalid, axi.bready}, 64'h1);
    wait_rsp(cyc);
    take_rsp();
    check("awfirst_one_write", 64'(write_count - wc), 64'd1);
    ref_mem[3] = 32'hAABB_5678;
    w_delay = 0;
    issue(1'b0, 12'h00C, 32'h0, 4'h0);
    wait_rsp(cyc);
    check("strobe_merge", {32'd0, rsp_rdata}, 64'hAABB_5678);
    take_rsp();
    check("early_bready", {63'd0, early_bready}, 64'd0);

    // ---- SLVERR write, response held 10 cycles ----
    bresp_cfg = AXI_RESP_SLVERR;
    issue(1'b1, 12'h010, 32'h5555_AAAA, 4'hF);
    wait_rsp(cyc);
    check("slverr_resp", {62'd0, rsp_resp}, 64'h2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_rsp_resp", {62'd0, rsp_resp}, 64'h2);
      check("hold_rsp_write", {63'd0, rsp_write}, 64'd1);
      check("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    take_rsp();
    ref_mem[4] = 32'h5555_AAAA;
    bresp_cfg = AXI_RESP_OKAY;

    // ---- DECERR read passes through with data ----
    rresp_cfg = AXI_RESP_DECERR;
    issue(1'b0, 12'h004, 32'h0, 4'h0);
    wait_rsp(cyc);
    check("decerr_resp", {62'd0, rsp_resp}, 64'h3);
    check("decerr_rdata", {32'd0, rsp_rdata}, 64'h1);
    take_rsp();
    rresp_cfg = AXI_RESP_OKAY;

    // ---- reset while in READ_DATA ----
    r_delay = 20;
    issue(1'b0, 12'h004, 32'h0, 4'h0);
    n = 0;
    while (!axi.rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reached_read_data", {63'd0, axi.rready}, 64'd1);
    #2 rst_n = 1'b0;
    #1 check("midrst_ar_r", {62'd0, axi.arvalid, axi.rready}, 64'd0);
    check("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    r_delay = 0;
    @(negedge clk);
    check("postrst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    check("postrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    issue(1'b1, 12'h004, 32'hCAFE_F00D, 4'hF);
    wait_rsp(cyc);
    take_rsp();
    ref_mem[1] = 32'hCAFE_F00D;
    issue(1'b0, 12'h004, 32'h0, 4'h0);
    wait_rsp(cyc);
    check("postrst_read", {32'd0, rsp_rdata}, 64'hCAFE_F00D);
    take_rsp();

    // ---- random traffic against the register model ----
    exp_writes = 0; wc = write_count;
    for (int t = 0; t < 100; t++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom_range(0, 3));
      rresp_cfg = 2'($urandom_range(0, 3));
      wr  = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      issue(wr, {6'd0, idx, 2'b00}, d, s);
      wait_rsp(cyc);
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
        exp_data = '0;
        exp_resp = bresp_cfg;
        exp_writes++;
      end else begin
        exp_data = ref_mem[idx];
        exp_resp = rresp_cfg;
      end
      check("rand_rsp_write", {63'd0, rsp_write}, {63'd0, wr});
      check("rand_rsp_resp", {62'd0, rsp_resp}, {62'd0, exp_resp});
      check("rand_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_data});
      repeat ($urandom_range(0, 2)) @(negedge clk);
      take_rsp();
    end
    check("rand_write_count", 64'(write_count - wc), 64'(exp_writes));
    check("protocol_violations", 64'(proto_viol), 64'd0);
    check("early_bready_final", {63'd0, early_bready}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
